// File: rtl/scroll_pkg.sv
// scroll_pkg: shared types and constants for the scroller controller.
package scroll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCROLL = 2'd2,
    PAUSED = 2'd3
  } scroll_state_e;

  localparam int SLOT_IDX_W = 4;
  localparam logic [4:0] BLANK_CODE = 5'h10;
  localparam int SPEED_W = 2;

  // Each speed step halves the shift period.
  function automatic int unsigned scaled_period(input int unsigned div,
                                                input logic [SPEED_W-1:0] speed);
    return div >> speed;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..period-1 and flags the wrap cycle; a shrunken
// period that the count already exceeds fires immediately and wraps.
module tick_prescaler #(
  parameter int CNT_W = 25
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] count;

  assign tick = !clear && !hold && (count >= (period - CNT_W'(1)));

  // Count register: clear beats hold, hold beats wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (hold) begin
      count <= count;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/scroll_ctrl.sv
// scroll_ctrl: loads a SLOTS-digit message into the display ring, then issues timed shift pulses.
// Build option SCROLL_ONESHOT_EN: stop after one full ring revolution and pulse done.
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int SLOTS    = 9,
  parameter int RING_LEN = 16,
  parameter int TICK_DIV = 25000000,
  parameter int DATA_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              digit_valid,
  input  logic [DATA_W-1:0] digit_data,
  output logic              digit_ready,
  input  logic              pause,
  input  logic              dir_in,
  input  logic [1:0]        speed,
  output logic              load_en,
  output logic [3:0]        load_sel,
  output logic [DATA_W-1:0] load_data,
  output logic              shift_en,
  output logic              shift_dir,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(TICK_DIV + 1);
  localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(SLOTS - 1);

  scroll_state_e          state;
  logic [SLOT_IDX_W-1:0]  index;
  logic [CNT_W-1:0]       period;
  logic                   clear;
  logic                   hold;
  logic                   tick;

`ifdef SCROLL_ONESHOT_EN
  localparam int SHIFT_W = $clog2(RING_LEN);
  localparam logic [SHIFT_W-1:0] LAST_SHIFT = SHIFT_W'(RING_LEN - 1);
  logic [SHIFT_W-1:0] shift_count;
  logic               final_shift;
`else
  assign done = 1'b0;
`endif

  // The prescaler only runs in SCROLL; a start in SCROLL/PAUSED restarts it from zero.
  assign period = CNT_W'(scaled_period(TICK_DIV, speed));
  assign clear  = abort | start | (state == IDLE) | (state == LOAD);
  assign hold   = pause | (state == PAUSED);

  tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .hold   (hold),
    .period (period),
    .tick   (tick)
  );

  // Controller FSM with registered strobes; priority abort > start > done > pause > tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      index       <= '0;
      digit_ready <= 1'b0;
      load_en     <= 1'b0;
      load_sel    <= 4'd0;
      load_data   <= '0;
      shift_en    <= 1'b0;
      shift_dir   <= 1'b0;
      busy        <= 1'b0;
`ifdef SCROLL_ONESHOT_EN
      done        <= 1'b0;
      shift_count <= '0;
      final_shift <= 1'b0;
`endif
    end else begin
      load_en  <= 1'b0;
      shift_en <= 1'b0;
`ifdef SCROLL_ONESHOT_EN
      done     <= 1'b0;
`endif
      if (abort) begin
        state       <= IDLE;
        digit_ready <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state       <= LOAD;
              index       <= '0;
              digit_ready <= 1'b1;
              busy        <= 1'b1;
            end
          end
          LOAD: begin
            if (digit_valid && digit_ready) begin
              load_en   <= 1'b1;
              load_sel  <= index;
              load_data <= digit_data;
              index     <= index + SLOT_IDX_W'(1);
              if (index == LAST_SLOT) begin
                state       <= SCROLL;
                digit_ready <= 1'b0;
`ifdef SCROLL_ONESHOT_EN
                shift_count <= '0;
                final_shift <= 1'b0;
`endif
              end
            end
          end
          SCROLL: begin
            if (start) begin
              state       <= LOAD;
              index       <= '0;
              digit_ready <= 1'b1;
`ifdef SCROLL_ONESHOT_EN
            end else if (final_shift) begin
              state       <= IDLE;
              busy        <= 1'b0;
              done        <= 1'b1;
              final_shift <= 1'b0;
`endif
            end else if (pause) begin
              state <= PAUSED;
            end else if (tick) begin
              shift_en  <= 1'b1;
              shift_dir <= dir_in;
`ifdef SCROLL_ONESHOT_EN
              if (shift_count == LAST_SHIFT) begin
                shift_count <= '0;
                final_shift <= 1'b1;
              end else begin
                shift_count <= shift_count + SHIFT_W'(1);
              end
`endif
            end
          end
          PAUSED: begin
            if (start) begin
              state       <= LOAD;
              index       <= '0;
              digit_ready <= 1'b1;
            end else if (!pause) begin
              state <= SCROLL;
            end
          end
          default: begin
            state       <= IDLE;
            digit_ready <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scroll_ctrl.sv
// tb_scroll_ctrl: randomized bench; a behavioural model queues expected strobes, a monitor checks them.
module tb_scroll_ctrl;

  localparam int SLOTS    = 9;
  localparam int RING_LEN = 16;
  localparam int TICK_DIV = 8;
  localparam int DATA_W   = 4;

  localparam int M_IDLE = 0, M_LOAD = 1, M_SCROLL = 2, M_PAUSED = 3;
  localparam int EV_LOAD = 0, EV_SHIFT = 1, EV_DONE = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              start, abort, digit_valid, pause, dir_in;
  logic [DATA_W-1:0] digit_data;
  logic [1:0]        speed;
  logic              digit_ready, load_en, shift_en, shift_dir, busy, done;
  logic [3:0]        load_sel;
  logic [DATA_W-1:0] load_data;

  typedef struct {
    int stamp;
    int kind;
    int a;
    int b;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_assert = 0;
  int  n_fail = 0;

  // Reference model state (message phase, elapsed cycles in the current shift period).
  int m_state, m_idx, m_elapsed, m_shifts, m_dir, m_ready;
  bit m_final;

  scroll_ctrl #(
    .SLOTS(SLOTS), .RING_LEN(RING_LEN), .TICK_DIV(TICK_DIV), .DATA_W(DATA_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .digit_valid(digit_valid), .digit_data(digit_data), .digit_ready(digit_ready),
    .pause(pause), .dir_in(dir_in), .speed(speed),
    .load_en(load_en), .load_sel(load_sel), .load_data(load_data),
    .shift_en(shift_en), .shift_dir(shift_dir), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_idx = 0; m_elapsed = 0; m_shifts = 0;
    m_dir = 0; m_ready = 0; m_final = 1'b0;
  endtask

  task automatic enter_load();
    m_state = M_LOAD; m_idx = 0; m_ready = 1; m_elapsed = 0;
  endtask

  // Advance model and DUT by one clock with the inputs currently driven.
  task automatic step();
    int p, stamp;
    p = TICK_DIV >> speed;
    stamp = cyc + 1;
    if (abort) begin
      m_state = M_IDLE; m_ready = 0;
    end else begin
      case (m_state)
        M_IDLE: if (start) enter_load();
        M_LOAD: begin
          if (digit_valid) begin
            exp_q.push_back('{stamp, EV_LOAD, m_idx, int'(digit_data)});
            m_idx++;
            if (m_idx == SLOTS) begin
              m_state = M_SCROLL; m_ready = 0; m_elapsed = 0;
              m_shifts = 0; m_final = 1'b0;
            end
          end
        end
        M_SCROLL: begin
          if (start) enter_load();
          else if (m_final) begin
            exp_q.push_back('{stamp, EV_DONE, 0, 0});
            m_state = M_IDLE; m_final = 1'b0;
          end else if (pause) m_state = M_PAUSED;
          else if (m_elapsed + 1 >= p) begin
            exp_q.push_back('{stamp, EV_SHIFT, int'(dir_in), 0});
            m_dir = int'(dir_in); m_elapsed = 0; m_shifts++;
`ifdef SCROLL_ONESHOT_EN
            if (m_shifts == RING_LEN) m_final = 1'b1;
`endif
          end else m_elapsed++;
        end
        default: begin
          if (start) enter_load();
          else if (!pause) m_state = M_SCROLL;
        end
      endcase
    end
    @(posedge clock);
    @(negedge clock);
    chk("busy", int'(busy), int'(m_state != M_IDLE));
    chk("digit_ready", int'(digit_ready), m_ready);
    chk("shift_dir_stable", int'(shift_dir), m_dir);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Stream digits until the model leaves LOAD; bounded so a stuck DUT cannot hang the run.
  task automatic feed(input bit gaps);
    for (int i = 0; i < 300 && m_state == M_LOAD; i++) begin
      digit_valid = gaps ? 1'($urandom_range(1)) : 1'b1;
      digit_data  = DATA_W'($urandom);
      step();
    end
    digit_valid = 1'b0;
  endtask

  task automatic load_msg(input bit gaps);
    start = 1'b1;
    step();
    feed(gaps);
  endtask

  // Monitor: pop an expectation whenever the DUT presents a strobe.
  always @(negedge clock) begin
    ev_t e;
    int k, a, b;
    if (!reset) begin
      if (load_en && shift_en) chk("load_shift_exclusive", 1, 0);
      if (load_en || shift_en || done) begin
        k = load_en ? EV_LOAD : (shift_en ? EV_SHIFT : EV_DONE);
        a = load_en ? int'(load_sel) : (shift_en ? int'(shift_dir) : 0);
        b = load_en ? int'(load_data) : 0;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: cycle %0d kind %0d a %0d b %0d, none expected", cyc, k, a, b);
        end else begin
          e = exp_q.pop_front();
          if (e.stamp != cyc || e.kind != k || e.a != a || e.b != b) begin
            n_fail++;
            $display("FAIL strobe: got cycle %0d kind %0d a %0d b %0d expected cycle %0d kind %0d a %0d b %0d",
                     cyc, k, a, b, e.stamp, e.kind, e.a, e.b);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].stamp <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_strobe_kind", -1, e.kind);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; digit_valid = 1'b0; digit_data = '0;
    pause = 1'b0; dir_in = 1'b0; speed = 2'd0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_load_en", int'(load_en), 0);
    chk("rst_shift_en", int'(shift_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_digit_ready", int'(digit_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_load_sel", int'(load_sel), 0);
    reset = 1'b0;

    // Fixed message 9..1 with valid held high, then speed-0 scrolling with random direction.
    start = 1'b1;
    step();
    for (int d = 9; d >= 1; d--) begin
      digit_valid = 1'b1; digit_data = DATA_W'(d); step();
    end
    digit_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin dir_in = 1'($urandom); step(); end

    // Speed changes, including shrinking the period below the running count.
    speed = 2'd2; run(12);
    speed = 2'd0; run(5);
    speed = 2'd3; run(5);
    speed = 2'd1; run(10);
    speed = 2'd0; run(5);

    // Direction toggling between pulses, then a long pause.
    for (int i = 0; i < 16; i++) begin dir_in = ~dir_in; step(); end
    pause = 1'b1; run(20);
    pause = 1'b0; run(20);

    // Abort on the 4th handshake, then reload with gaps.
    start = 1'b1; step();
    for (int i = 0; i < 100 && m_idx < 3; i++) begin
      digit_valid = 1'($urandom_range(1)); digit_data = DATA_W'($urandom); step();
    end
    digit_valid = 1'b1; abort = 1'b1; step();
    digit_valid = 1'b0; run(5);
    load_msg(1'b1); run(20);

    // start+abort together in SCROLL, then start while paused.
    start = 1'b1; abort = 1'b1; step(); run(5);
    load_msg(1'b0); run(5);
    pause = 1'b1; run(3);
    start = 1'b1; step();
    pause = 1'b0; feed(1'b1); run(10);

    // One full revolution at speed 1 (oneshot builds stop here).
    speed = 2'd1;
    for (int i = 0; i < 94; i++) begin dir_in = 1'($urandom); step(); end

    // Random soak.
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(59) == 0);
      abort = ($urandom_range(149) == 0);
      if ($urandom_range(24) == 0) pause = ~pause;
      if ($urandom_range(6) == 0) dir_in = ~dir_in;
      if ($urandom_range(29) == 0) speed = 2'($urandom);
      digit_valid = ($urandom_range(2) != 0);
      digit_data  = DATA_W'($urandom);
      step();
    end
    pause = 1'b0; digit_valid = 1'b0; speed = 2'd0;

    // Asynchronous reset in the middle of scrolling.
    load_msg(1'b0); run(11);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_shift_dir", int'(shift_dir), 0);
    chk("arst_load_sel", int'(load_sel), 0);
    chk("arst_digit_ready", int'(digit_ready), 0);
    exp_q.delete();
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    load_msg(1'b0); run(20);

    @(negedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/scroll_ctrl.md
Name: scroll_ctrl

Overview:
Controller that sequences the 16-entry rotating 5-bit digit ring feeding the 7-segment scroller.
- Accepts a message of up to 9 digits over a valid/ready stream and writes them slot by slot into the ring.
- Then issues timed single-cycle shift pulses with selectable speed and direction.
- Sits between the switch/button front end and the ring register.

Parameters:
SLOTS, 9, number of visible slots loaded per message (1..9)
RING_LEN, 16, total ring positions; used by the optional one-shot stop
TICK_DIV, 25000000, clock cycles per shift at speed 0 (>=8)
DATA_W, 4, digit width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: begin loading a new message
abort  in  1  level: return to IDLE immediately
digit_valid  in  1  digit stream valid
digit_data  in  DATA_W  digit value
digit_ready  out  1  controller accepts digit this cycle
pause  in  1  level: freeze shift timing
dir_in  in  1  requested direction (1 = toward higher slot)
speed  in  2  period = TICK_DIV >> speed
load_en  out  1  one-cycle write strobe to ring
load_sel  out  4  slot index for write
load_data  out  DATA_W  value for write
shift_en  out  1  one-cycle shift pulse
shift_dir  out  1  direction for the shift_en pulse
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at one-shot completion

Behaviour:
- Reset is asynchronous and active-high; clock is `clock`.
- Reset values: state=IDLE; slot index=0; prescaler=0; every output is 0.
- All outputs are registered.
- States: IDLE, LOAD, SCROLL, PAUSED.
- IDLE:
  - digit_ready=0.
  - start=1 -> LOAD, slot index cleared to 0.
- LOAD:
  - digit_ready=1.
  - Handshake = digit_valid & digit_ready.
  - Each handshake drives load_en=1, load_sel=index, load_data=digit_data in the following cycle, then index+1.
  - After the SLOTS-th handshake: digit_ready drops in that cycle's next edge and state -> SCROLL.
  - The last load_en is issued in the first SCROLL cycle.
  - start in LOAD is ignored.
  - Valid gaps are allowed with no timeout.
- SCROLL:
  - The prescaler counts 0..P-1 with P = TICK_DIV >> speed.
  - At count P-1: shift_en=1 for one cycle, shift_dir = dir_in sampled that cycle, prescaler -> 0.
  - First shift_en occurs P cycles after SCROLL entry.
  - A speed change takes effect immediately. If the prescaler is already >= the new P-1, it fires on the next cycle and wraps.
  - A dir_in change applies only at the next pulse; no glitch on shift_dir between pulses.
  - start in SCROLL -> LOAD (reload), prescaler cleared, no shift_en that cycle.
- PAUSED:
  - Entered from SCROLL while pause=1; prescaler holds its value and shift_en=0.
  - pause=0 -> SCROLL, counting resumes from the held value.
  - start in PAUSED -> LOAD.
- Abort has priority over all other inputs.
  - abort=1 in any state -> IDLE next edge.
  - load_en, shift_en and digit_ready are 0 from that edge.
  - Ring contents are untouched.
- Priority for simultaneous events: abort > start > pause > prescaler tick.
- load_en and shift_en are never both 1 in the same cycle.
- Reset mid-LOAD or mid-SCROLL: outputs drop asynchronously and index is cleared.

Optional Feature:
SCROLL_ONESHOT_EN
- Defined: a shift counter (0..RING_LEN-1) is cleared on SCROLL entry.
  - After the RING_LEN-th shift_en, the next edge gives done=1 for one cycle and state -> IDLE.
  - The message returns to its load position.
  - Pause freezes the counter.
- Undefined: scrolling continues indefinitely, and done is tied to 0.

Decomposition:
- Package scroll_pkg holds:
  - state enum scroll_state_e (IDLE, LOAD, SCROLL, PAUSED)
  - SLOT_IDX_W=4
  - BLANK_CODE=5'h10
  - speed-to-shift constants
- Sub-module tick_prescaler:
  - Inputs: clock, reset, clear, hold, period.
  - Output: tick.
  - Instantiated once; owns the counter and its wrap/early-fire rule.

Test Plan (TICK_DIV=8):
1. Reset, start, stream 9,8,...,1 with valid held high -> load_en on 9 consecutive cycles, load_sel 0..8, load_data 9..1, then shift_en every 8 cycles with shift_dir=dir_in.
2. In SCROLL at speed=0, set speed=2 -> period becomes 2; pulse spacing 2 cycles from the next tick; no two consecutive-cycle pulses except the early-fire wrap case.
3. Toggle dir_in between pulses -> shift_dir changes only on the pulse cycle; hold pause 20 cycles -> no shift_en and the prescaler value is retained on release.
4. Assert abort on the 4th handshake of LOAD -> IDLE next edge, no further load_en, busy=0; a new start reloads from slot 0.
5. start and abort asserted in the same cycle during SCROLL -> IDLE; start with pause=1 in PAUSED -> LOAD.
6. With SCROLL_ONESHOT_EN defined -> exactly 16 shift_en pulses, then done=1 for one cycle and busy=0. Without it -> pulses continue past 16 and done stays 0.
